// File: rtl/dispatch_queue_pkg.sv
// Shared definitions for the dispatch queue: lane count, data widths,
// queue depth, branch opcodes and the dispatch packet layout.
package dispatch_queue_pkg;

    localparam int N_WAY           = 3;
    localparam int XLEN            = 32;
    localparam int DQ_DEPTH        = 16;
    localparam int EX_BRANCH_UNITS = 1;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } DISPATCH_PACKET_R10K;

    // Control-transfer instructions are tagged so the core can steer them
    // to a branch unit.
    function automatic logic is_branch_op(input logic [31:0] inst);
        return (inst[6:0] == OPC_BRANCH) ||
               (inst[6:0] == OPC_JAL)    ||
               (inst[6:0] == OPC_JALR);
    endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Fetch-side and dispatch-side handshake of the dispatch queue.
// master: fetch unit plus core dispatch logic; slave: the queue itself.
interface dispatch_queue_if;
    import dispatch_queue_pkg::*;

    DISPATCH_PACKET_R10K fetch_packet [N_WAY];
    logic                fetch_valid;
    logic                fetch_ready;
    DISPATCH_PACKET_R10K dispatch_out [N_WAY];
    logic [N_WAY-1:0]    branch_inst;
    logic [N_WAY-1:0]    dispatched;

    modport master (
        output fetch_packet,
        output fetch_valid,
        output dispatched,
        input  fetch_ready,
        input  dispatch_out,
        input  branch_inst
    );

    modport slave (
        input  fetch_packet,
        input  fetch_valid,
        input  dispatched,
        output fetch_ready,
        output dispatch_out,
        output branch_inst
    );
endinterface

// File: rtl/dispatch_queue_lead_ones.sv
// dq_lead_ones: number of contiguous ones in a mask counted from bit 0.
// Used for the in-order pop count and the packed push count.
module dq_lead_ones #(
    parameter int W    = 3,
    parameter int CNTW = $clog2(W + 1)
) (
    input  logic [W-1:0]    mask,
    output logic [CNTW-1:0] count
);

    logic run;

    // Count stops at the first zero; ones above it are ignored.
    always_comb begin
        count = '0;
        run   = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (!mask[i]) begin
                run = 1'b0;
            end
            if (run) begin
                count = CNTW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order circular instruction buffer between fetch and
// the core dispatch port. Pushes packed fetch groups, pops the leading run
// of dispatched lanes, flushes on branch_haz and issues a one-cycle redirect.
// Optional macro DISPATCH_QUEUE_PERF_EN adds saturating perf counters.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int W     = N_WAY,
    parameter int DEPTH = DQ_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    dispatch_queue_if.slave dq,
    input  logic            branch_haz,
    input  logic [XLEN-1:0] br_target_pc [EX_BRANCH_UNITS],
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
`ifdef DISPATCH_QUEUE_PERF_EN
    ,
    output logic [31:0]     perf_full_stall,
    output logic [31:0]     perf_empty,
    output logic [31:0]     perf_flush
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int KW = $clog2(W + 1);

    logic [AW-1:0]       head;
    logic [AW-1:0]       tail;
    logic [CW-1:0]       count;
    DISPATCH_PACKET_R10K mem [DEPTH];

    logic [W-1:0]        lane_valid;
    logic [W-1:0]        fetch_mask;
    logic [W-1:0]        pop_mask;
    logic [KW-1:0]       pop_cnt;
    logic [KW-1:0]       push_cnt;
    logic                push_en;
    DISPATCH_PACKET_R10K entry;

    // Present the oldest W entries; valid comes from occupancy, not storage.
    always_comb begin
        entry = '0;
        for (int i = 0; i < W; i++) begin
            lane_valid[i]      = (CW'(i) < count);
            entry              = mem[head + AW'(i)];
            entry.valid        = lane_valid[i];
            dq.dispatch_out[i] = entry;
            dq.branch_inst[i]  = lane_valid[i] && is_branch_op(entry.inst);
            fetch_mask[i]      = dq.fetch_packet[i].valid;
        end
    end

    // Ready depends only on current occupancy so fetch never relies on a same-cycle pop.
    assign dq.fetch_ready = (count <= CW'(DEPTH - W));
    assign pop_mask       = dq.dispatched & lane_valid;
    assign push_en        = dq.fetch_valid && dq.fetch_ready;

    dq_lead_ones #(.W(W), .CNTW(KW)) u_pop_cnt (
        .mask  (pop_mask),
        .count (pop_cnt)
    );

    dq_lead_ones #(.W(W), .CNTW(KW)) u_push_cnt (
        .mask  (fetch_mask),
        .count (push_cnt)
    );

    // Pointer, occupancy and redirect state; a flush wins over push and pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (branch_haz) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            redirect_valid <= 1'b1;
            redirect_pc    <= br_target_pc[0];
        end else begin
            redirect_valid <= 1'b0;
            head           <= head + AW'(pop_cnt);
            if (push_en) begin
                tail  <= tail + AW'(push_cnt);
                count <= count - CW'(pop_cnt) + CW'(push_cnt);
            end else begin
                count <= count - CW'(pop_cnt);
            end
        end
    end

    // Entry storage; stale contents are masked by the occupancy-derived valid.
    always_ff @(posedge clock) begin
        if (push_en && !branch_haz) begin
            for (int i = 0; i < W; i++) begin
                if (KW'(i) < push_cnt) begin
                    mem[tail + AW'(i)] <= dq.fetch_packet[i];
                end
            end
        end
    end

`ifdef DISPATCH_QUEUE_PERF_EN
    // Saturating event counters; only reset clears them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_full_stall <= '0;
            perf_empty      <= '0;
            perf_flush      <= '0;
        end else begin
            if (dq.fetch_valid && !dq.fetch_ready && (perf_full_stall != '1)) begin
                perf_full_stall <= perf_full_stall + 32'd1;
            end
            if ((count == '0) && (perf_empty != '1)) begin
                perf_empty <= perf_empty + 32'd1;
            end
            if (branch_haz && (perf_flush != '1)) begin
                perf_flush <= perf_flush + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    logic        clock;
    logic        reset;
    logic        branch_haz;
    logic [31:0] br_target_pc [EX_BRANCH_UNITS];
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef DISPATCH_QUEUE_PERF_EN
    logic [31:0] perf_full_stall;
    logic [31:0] perf_empty;
    logic [31:0] perf_flush;
`endif

    dispatch_queue_if dq_if ();

    dispatch_queue dut (
        .clock          (clock),
        .reset          (reset),
        .dq             (dq_if.slave),
        .branch_haz     (branch_haz),
        .br_target_pc   (br_target_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef DISPATCH_QUEUE_PERF_EN
        ,
        .perf_full_stall(perf_full_stall),
        .perf_empty     (perf_empty),
        .perf_flush     (perf_flush)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq [$];
    logic        exp_rv;
    logic [31:0] exp_rpc;
    int          n_checks;
    int          n_fail;
    logic [31:0] seq_pc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_br(input logic [31:0] inst);
        return inst[6:0] == 7'h63 || inst[6:0] == 7'h6f || inst[6:0] == 7'h67;
    endfunction

    function automatic logic [31:0] mk_inst(input int kind);
        logic [31:0] r;
        r = $urandom();
        case (kind)
            0:       r[6:0] = 7'b1100011;
            1:       r[6:0] = 7'b1101111;
            2:       r[6:0] = 7'b1100111;
            3:       r[6:0] = 7'b0110011;
            default: r[6:0] = 7'b0010011;
        endcase
        return r;
    endfunction

    task automatic set_lane(input int i, input bit v, input logic [31:0] inst);
        dq_if.fetch_packet[i] = '{valid: v, pc: seq_pc, inst: inst};
        seq_pc = seq_pc + 32'd4;
    endtask

    task automatic set_group(input logic [2:0] vmask);
        for (int i = 0; i < N_WAY; i++) begin
            set_lane(i, vmask[i], mk_inst($urandom_range(0, 4)));
        end
    endtask

    task automatic idle_inputs();
        dq_if.fetch_valid = 1'b0;
        dq_if.dispatched  = '0;
        branch_haz        = 1'b0;
        set_group(3'b000);
    endtask

    task automatic check_outputs();
        logic [2:0] exp_br;
        bit         v;
        exp_br = '0;
        for (int i = 0; i < N_WAY; i++) begin
            v = (i < mq.size());
            check("lane_valid", 64'(dq_if.dispatch_out[i].valid), 64'(v));
            if (v) begin
                check("lane_pc", 64'(dq_if.dispatch_out[i].pc), 64'(mq[i].pc));
                check("lane_inst", 64'(dq_if.dispatch_out[i].inst), 64'(mq[i].inst));
                exp_br[i] = is_br(mq[i].inst);
            end
        end
        check("branch_inst", 64'(dq_if.branch_inst), 64'(exp_br));
        check("fetch_ready", 64'(dq_if.fetch_ready), 64'((16 - mq.size()) >= 3));
        check("redirect_valid", 64'(redirect_valid), 64'(exp_rv));
        if (exp_rv) begin
            check("redirect_pc", 64'(redirect_pc), 64'(exp_rpc));
        end
    endtask

    // Inputs are already applied; check at negedge, advance the model, cross the edge.
    task automatic step();
        int  k;
        bit  ready;
        @(negedge clock);
        check_outputs();
        ready = (16 - mq.size()) >= 3;
        if (branch_haz) begin
            mq.delete();
            exp_rv  = 1'b1;
            exp_rpc = br_target_pc[0];
        end else begin
            exp_rv = 1'b0;
            k = 0;
            while (k < 3 && k < mq.size() && dq_if.dispatched[k]) k++;
            repeat (k) void'(mq.pop_front());
            if (dq_if.fetch_valid && ready) begin
                for (int i = 0; i < N_WAY; i++) begin
                    if (!dq_if.fetch_packet[i].valid) break;
                    mq.push_back('{pc: dq_if.fetch_packet[i].pc, inst: dq_if.fetch_packet[i].inst});
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b0;
        mq.delete();
        exp_rv = 1'b0;
        #1;
        check_outputs();
        check("redirect_pc_rst", 64'(redirect_pc), 64'h0);
        repeat (ncyc) @(posedge clock);
        #1;
        check_outputs();
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        seq_pc   = 32'h1000;
        exp_rv   = 1'b0;
        exp_rpc  = '0;
        br_target_pc[0] = '0;
        reset = 1'b1;
        idle_inputs();
        @(posedge clock);
        #1;

        // Reset then idle
        do_reset(3);
        repeat (2) step();

        // Fill: six full groups with nothing dispatched; the sixth is held
        dq_if.fetch_valid = 1'b1;
        for (int g = 0; g < 6; g++) begin
            set_group(3'b111);
            step();
        end
        check("fill_level", 64'(mq.size()), 64'd15);
        dq_if.fetch_valid = 1'b0;
        dq_if.dispatched  = 3'b111;
        repeat (6) step();

        // Partial dispatch: A,B,C,D queued, dispatched=101 retires only A
        idle_inputs();
        dq_if.fetch_valid = 1'b1;
        set_group(3'b111);
        step();
        set_group(3'b001);
        step();
        dq_if.fetch_valid = 1'b0;
        dq_if.dispatched  = 3'b101;
        step();
        dq_if.dispatched  = 3'b000;
        step();
        dq_if.dispatched  = 3'b111;
        repeat (2) step();

        // Flush with simultaneous push, then back-to-back flushes
        dq_if.fetch_valid = 1'b1;
        set_group(3'b111);
        step();
        set_group(3'b111);
        branch_haz      = 1'b1;
        br_target_pc[0] = 32'h0000_0040;
        step();
        br_target_pc[0] = 32'h0000_0080;
        step();
        branch_haz = 1'b0;
        idle_inputs();
        step();
        step();

        // Wrap-around: steady push 3 / pop 3 across the index boundary
        dq_if.fetch_valid = 1'b1;
        set_group(3'b111);
        step();
        dq_if.dispatched = 3'b111;
        for (int c = 0; c < 10; c++) begin
            set_group(3'b111);
            step();
            check("wrap_level", 64'(mq.size()), 64'd3);
        end
        idle_inputs();
        dq_if.dispatched = 3'b111;
        repeat (2) step();

        // Branch tagging: JAL, ADD, BEQ
        idle_inputs();
        dq_if.fetch_valid = 1'b1;
        set_lane(0, 1'b1, mk_inst(1));
        set_lane(1, 1'b1, mk_inst(3));
        set_lane(2, 1'b1, mk_inst(0));
        step();
        idle_inputs();
        @(negedge clock);
        check("branch_tag", 64'(dq_if.branch_inst), 64'b101);
        @(posedge clock);
        #1;
        dq_if.dispatched = 3'b111;
        step();

        // Randomized traffic with one mid-run reset
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                idle_inputs();
                do_reset(1);
            end
            dq_if.fetch_valid = ($urandom_range(0, 3) != 0);
            set_group(3'($urandom_range(0, 7)));
            dq_if.dispatched = 3'($urandom_range(0, 7));
            branch_haz       = ($urandom_range(0, 15) == 0);
            br_target_pc[0]  = $urandom();
            step();
        end
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
